// File: rtl/sw_pkg.sv
// Shared definitions for the stopwatch control slice: FSM state encodings,
// default timing parameters and a counter-width helper.
package sw_pkg;

    typedef enum logic [1:0] {
        ST_CLEARED = 2'd0,
        ST_RUNNING = 2'd1,
        ST_STOPPED = 2'd2
    } sw_state_e;

    // Defaults assume a 50 MHz clk_in.
    localparam int unsigned TICK_DIV_DEF    = 500_000;      // 10 ms tick
    localparam int unsigned DEB_CYCLES_DEF  = 1_000_000;    // 20 ms debounce
    localparam int unsigned HOLD_CYCLES_DEF = 100_000_000;  // 2 s hold-to-clear

    // Width of a counter spanning 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus debounce counter for one raw input; emits the
// accepted level and one-cycle pulses on its falling (press) and rising edges.
module btn_debounce
    import sw_pkg::*;
#(
    parameter int unsigned DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter logic        RESET_LEVEL = 1'b1
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic pressed,
    output logic released
);

    localparam int unsigned     CW      = cnt_width(DEB_CYCLES);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= {2{RESET_LEVEL}};
            level    <= RESET_LEVEL;
            cnt      <= '0;
            pressed  <= 1'b0;
            released <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], raw};
            pressed  <= 1'b0;
            released <= 1'b0;
            if (sync_q[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                // New level held long enough: accept it and flag the edge.
                level    <= sync_q[1];
                cnt      <= '0;
                pressed  <= ~sync_q[1];
                released <= sync_q[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch input conditioning and start/stop/clear control: drives the
// downstream digit counter with run, a 10 ms tick and a clear pulse.
module stopwatch_ctrl
    import sw_pkg::*;
#(
    parameter int unsigned TICK_DIV    = TICK_DIV_DEF,
    parameter int unsigned DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       switch,
    input  logic       btn,
    output logic       run,
    output logic       tick,
    output logic       clr,
    output logic [1:0] state
);

    localparam int unsigned   PW        = cnt_width(TICK_DIV);
    localparam int unsigned   HW        = cnt_width(HOLD_CYCLES);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES - 1);

    logic          sw_q1, sw_s;
    logic          btn_lvl, press, release_evt;
    sw_state_e     state_q, state_nxt;
    logic [PW-1:0] presc;
    logic [HW-1:0] hold_cnt;
    logic          armed;
    logic          hold_done;
    logic          enter_clr;

    btn_debounce #(
        .DEB_CYCLES  (DEB_CYCLES),
        .RESET_LEVEL (1'b1)
    ) u_btn_debounce (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .raw      (btn),
        .level    (btn_lvl),
        .pressed  (press),
        .released (release_evt)
    );

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = ST_CLEARED;
        hold_done = (state_q == ST_STOPPED) && !btn_lvl && (hold_cnt == HOLD_MAX);
        case (state_q)
            ST_CLEARED: state_nxt = (press && sw_s) ? ST_RUNNING : ST_CLEARED;
            ST_RUNNING: state_nxt = (press || !sw_s) ? ST_STOPPED : ST_RUNNING;
            ST_STOPPED: begin
                if (hold_done)
                    state_nxt = ST_CLEARED;
                else if (release_evt && armed && sw_s)
                    state_nxt = ST_RUNNING;
                else
                    state_nxt = ST_STOPPED;
            end
            default:    state_nxt = ST_CLEARED;
        endcase
        enter_clr = (state_nxt == ST_CLEARED) && (state_q != ST_CLEARED);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sw_q1    <= 1'b0;
            sw_s     <= 1'b0;
            state_q  <= ST_CLEARED;
            run      <= 1'b0;
            tick     <= 1'b0;
            clr      <= 1'b0;
            presc    <= '0;
            hold_cnt <= '0;
            armed    <= 1'b0;
        end else begin
            sw_q1   <= switch;
            sw_s    <= sw_q1;
            state_q <= state_nxt;
            run     <= (state_nxt == ST_RUNNING);
            clr     <= enter_clr;
            tick    <= 1'b0;

            // Prescaler freezes outside RUNNING so a restart resumes mid-period.
            if (enter_clr) begin
                presc <= '0;
            end else if (state_q == ST_RUNNING) begin
                if (presc == PRESC_MAX) begin
                    presc <= '0;
                    tick  <= 1'b1;
                end else begin
                    presc <= presc + 1'b1;
                end
            end

            if (state_q == ST_STOPPED && !btn_lvl && !hold_done)
                hold_cnt <= hold_cnt + 1'b1;
            else
                hold_cnt <= '0;

            // Only a press made while already stopped may arm a restart.
            armed <= (state_nxt == ST_STOPPED) &&
                     (armed || (state_q == ST_STOPPED && press));
        end
    end

    assign state = state_q;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Input-conditioning and control stage directly upstream of the six-digit stopwatch counter/display block.
- Synchronises and debounces the run slide switch and the active-low pushbutton.
- Runs a start/stop/clear state machine.
- Drives the downstream counter with a 1-cycle 10 ms count tick, a 1-cycle clear pulse and a run level, so the counter no longer needs its own prescaler or raw-button handling.

Parameters:
- TICK_DIV, 500_000: clk_in cycles per tick (50 MHz to 10 ms).
- DEB_CYCLES, 1_000_000: cycles a changed button level must be stable before it is accepted (20 ms).
- HOLD_CYCLES, 100_000_000: cycles the button must be held in STOPPED to clear (2 s).
- All counter widths are derived with $clog2 of the corresponding parameter.

Ports:
- clk_in  input  1  system clock, 50 MHz
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low
- switch  input  1  raw slide switch; 1 = stopwatch enabled
- btn  input  1  raw pushbutton, active-low (0 = pressed)
- run  output  1  high while state == RUNNING
- tick  output  1  one-cycle pulse every TICK_DIV cycles spent in RUNNING
- clr  output  1  one-cycle pulse: zero all downstream digits
- state  output  2  current FSM state encoding

Behaviour:
- Reset values (async assert, sync release): state CLEARED, run 0, tick 0, clr 0, prescaler 0, debounce/hold counters 0.
- Synchroniser flops reset to switch 0 and btn 1 (released). The debounced btn level resets to 1.
- switch: 2-flop synchroniser only, no debounce. The internal sw_s is the second flop.
- btn path:
  - 2-flop synchroniser, then debounce counter.
  - While the synchronised level equals the stable level, the counter is held at 0.
  - While it differs, the counter increments. On reaching DEB_CYCLES-1, the stable level takes the new value and the counter returns to 0.
  - A glitch shorter than DEB_CYCLES resets the count and changes nothing.
  - press = 1-cycle pulse on stable 1->0; release = 1-cycle pulse on stable 0->1.
  - Latency from raw btn edge to press is 2 + DEB_CYCLES cycles.
- FSM encodings: CLEARED=2'd0, RUNNING=2'd1, STOPPED=2'd2. Encoding 2'd3 is illegal and recovers to CLEARED on the next clock.
  - CLEARED: press && sw_s goes to RUNNING. Otherwise stay.
  - RUNNING: press goes to STOPPED, and !sw_s goes to STOPPED. Both in the same cycle give STOPPED once.
  - STOPPED, hold counter:
    - Increments while the stable btn is 0; held at 0 otherwise.
    - On reaching HOLD_CYCLES-1 the FSM goes to CLEARED and clr pulses.
    - Clear is permitted with switch low.
  - STOPPED, restart:
    - A release occurring before hold expiry, with sw_s = 1, goes to RUNNING.
    - A release with sw_s = 0 stays in STOPPED.
    - The press that entered STOPPED does not itself arm a restart.
    - Restart requires a new press followed by its release. This is tracked by an armed flag, set on press in STOPPED and cleared on leaving STOPPED.
  - The release ending a clearing hold occurs in CLEARED and is ignored.
- Outputs:
  - run is registered and equals (next state == RUNNING), so it is aligned with state.
  - state is the registered FSM state.
- Prescaler:
  - Counts 0..TICK_DIV-1 only while in RUNNING, and freezes (retaining its phase) in STOPPED.
  - tick is registered high for exactly the cycle after the prescaler wraps from TICK_DIV-1 to 0.
  - The first tick after start occurs TICK_DIV cycles after run rises.
- clr:
  - Registered, high for exactly the cycle after entry to CLEARED.
  - Zeroes the prescaler in the same transition.
  - tick is never high in the same cycle as clr.
- Reset mid-operation: all state returns to reset values immediately, with no tick or clr pulse emitted.

Decomposition:
- Package sw_pkg: state encodings (ST_CLEARED, ST_RUNNING, ST_STOPPED) and default values for TICK_DIV, DEB_CYCLES and HOLD_CYCLES.
- One sub-module, btn_debounce (params DEB_CYCLES, RESET_LEVEL):
  - 2-flop sync, debounce counter, stable level, press and release pulses.
  - Instantiated once for btn.
- Switch sync and the FSM stay in stopwatch_ctrl.

Test Plan (TICK_DIV=5, DEB_CYCLES=4, HOLD_CYCLES=20):
- Reset with switch=1 and btn=1 held for 50 cycles -> state=0, run=0, tick=0, clr=0 throughout.
- switch=1; btn low for 10 cycles then high -> press 6 cycles after the edge; state=1 and run=1; tick pulses every 5 cycles, first tick 5 cycles after run rises.
- btn glitch low for 3 cycles while RUNNING -> no state change; tick spacing is unchanged.
- In RUNNING, press -> state=2, ticks stop. A new 8-cycle press and release -> state=1, and the first tick resumes at the frozen prescaler phase.
- In STOPPED, hold btn low for 30 cycles -> exactly one clr pulse about 20 cycles after press; state=0; the subsequent release keeps state=0.
- In RUNNING, drop switch -> state=2 after 2 sync cycles. A press/release with switch=0 keeps state=2. Assert rst_n low mid-count -> all outputs 0 asynchronously.
